stepper_axis_driver: RTL and testbench

Dual-axis stepper driver: the consumer of the 2-bit per-axis direction commands issued by the motion controller. For each axis (teta = vertical, fi = horizontal) it turns the held command into timed step/direction pulses and keeps a 0..359 degree position counter. The counters are fed back to the controller as `teta_actual` and `fi_actual`. It sits between the controller and the external motor-driver pins.

---
 rtl/motion_pkg.sv | 35 +++
 rtl/stepper_axis_channel.sv | 174 +++++++++++++++++
 rtl/stepper_axis_driver.sv | 87 ++++++++
 tb/tb_stepper_axis_driver.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
// ============================================================================
// motion_pkg : direction codes, angle constants and axis state encoding
//              shared by the motion controller and the stepper driver.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package motion_pkg;

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_NEG  = 2'b01;
    localparam logic [1:0] DIR_POS  = 2'b10;
    localparam logic [1:0] DIR_ILL  = 2'b11;

    localparam int DEG_FULL = 360;
    localparam int ANGLE_W  = 9;

    typedef enum logic [1:0] {
        AX_IDLE     = 2'd0,
        AX_SETUP    = 2'd1,
        AX_PULSE_HI = 2'd2,
        AX_PULSE_LO = 2'd3
    } axis_state_e;

    function automatic logic [ANGLE_W-1:0] angle_inc(input logic [ANGLE_W-1:0] a);
        return (a == ANGLE_W'(DEG_FULL - 1)) ? '0 : a + ANGLE_W'(1);
    endfunction

    function automatic logic [ANGLE_W-1:0] angle_dec(input logic [ANGLE_W-1:0] a);
        return (a == '0) ? ANGLE_W'(DEG_FULL - 1) : a - ANGLE_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/stepper_axis_channel.sv
// ============================================================================
// stepper_axis_channel : one stepper axis - step/dir timing FSM plus
//                        sub-step and 0..359 degree angle counters.
// Revision             : 1.0
// ============================================================================
`default_nettype none

module stepper_axis_channel
    import motion_pkg::*;
#(
    parameter int STEP_PERIOD   = 50000,
    parameter int PULSE_W       = 100,
    parameter int SETUP_CYC     = 20,
    parameter int STEPS_PER_DEG = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         cmd_i,
    input  logic               zero_i,
    output logic               step_o,
    output logic               dir_o,
    output logic [ANGLE_W-1:0] angle_o,
    output logic               busy_o,
    output logic               ill_o
);

    localparam int TMAX = (SETUP_CYC > STEP_PERIOD) ? SETUP_CYC : STEP_PERIOD;
    localparam int TW   = $clog2(TMAX);
    localparam int SW   = (STEPS_PER_DEG > 1) ? $clog2(STEPS_PER_DEG) : 1;

    localparam logic [TW-1:0] C_SETUP_LD = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] C_HI_LD    = TW'(PULSE_W - 1);
    localparam logic [TW-1:0] C_LO_LD    = TW'(STEP_PERIOD - PULSE_W - 1);
    localparam logic [SW-1:0] C_SUB_MAX  = SW'(STEPS_PER_DEG - 1);

    axis_state_e        state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               step_q, step_d;
    logic               dir_q, dir_d;
    logic [SW-1:0]      sub_q, sub_d;
    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic [1:0]         cmd_q;

    logic w_cmd_pos;
    logic w_cmd_neg;
    logic w_cmd_ill;
    logic w_tmr_zero;
    logic w_adv;
    logic w_ill;

    assign w_cmd_pos  = (cmd_q == DIR_POS);
    assign w_cmd_neg  = (cmd_q == DIR_NEG);
    assign w_cmd_ill  = (cmd_q == DIR_ILL);
    assign w_tmr_zero = (timer_q == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= AX_IDLE;
            timer_q <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            sub_q   <= '0;
            angle_q <= '0;
            cmd_q   <= DIR_STOP;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            sub_q   <= sub_d;
            angle_q <= angle_d;
            cmd_q   <= cmd_i;
        end
    end

    // Command is only looked at in IDLE and at the end of PULSE_LO, so a
    // started step always runs its full period.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        step_d  = step_q;
        dir_d   = dir_q;
        w_adv   = 1'b0;
        w_ill   = 1'b0;
        case (state_q)
            AX_IDLE: begin
                w_ill = w_cmd_ill;
                if (w_cmd_pos || w_cmd_neg) begin
                    dir_d   = w_cmd_pos;
                    timer_d = C_SETUP_LD;
                    state_d = AX_SETUP;
                end
            end
            AX_SETUP: begin
                if (w_tmr_zero) begin
                    step_d  = 1'b1;
                    w_adv   = 1'b1;
                    timer_d = C_HI_LD;
                    state_d = AX_PULSE_HI;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            AX_PULSE_HI: begin
                if (w_tmr_zero) begin
                    step_d  = 1'b0;
                    timer_d = C_LO_LD;
                    state_d = AX_PULSE_LO;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            AX_PULSE_LO: begin
                if (w_tmr_zero) begin
                    w_ill = w_cmd_ill;
                    if ((w_cmd_pos || w_cmd_neg) && (w_cmd_pos == dir_q)) begin
                        step_d  = 1'b1;
                        w_adv   = 1'b1;
                        timer_d = C_HI_LD;
                        state_d = AX_PULSE_HI;
                    end else if (w_cmd_pos || w_cmd_neg) begin
                        dir_d   = w_cmd_pos;
                        timer_d = C_SETUP_LD;
                        state_d = AX_SETUP;
                    end else begin
                        state_d = AX_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = AX_IDLE;
            end
        endcase
    end

    // Home strobe overrides any position update landing on the same edge.
    always_comb begin
        sub_d   = sub_q;
        angle_d = angle_q;
        if (zero_i) begin
            sub_d   = '0;
            angle_d = '0;
        end else if (w_adv) begin
            if (dir_q) begin
                if (sub_q == C_SUB_MAX) begin
                    sub_d   = '0;
                    angle_d = angle_inc(angle_q);
                end else begin
                    sub_d = sub_q + SW'(1);
                end
            end else begin
                if (sub_q == '0) begin
                    sub_d   = C_SUB_MAX;
                    angle_d = angle_dec(angle_q);
                end else begin
                    sub_d = sub_q - SW'(1);
                end
            end
        end
    end

    always_comb begin
        busy_o  = (state_q != AX_IDLE);
        step_o  = step_q;
        dir_o   = dir_q;
        angle_o = angle_q;
        ill_o   = w_ill;
    end

endmodule

`default_nettype wire

// File: rtl/stepper_axis_driver.sv
// ============================================================================
// stepper_axis_driver : dual-axis (teta/fi) stepper driver with shared sticky
//                       illegal-command flag.
// Revision            : 1.0
// ============================================================================
`default_nettype none

module stepper_axis_driver
    import motion_pkg::*;
#(
    parameter int STEP_PERIOD   = 50000,
    parameter int PULSE_W       = 100,
    parameter int SETUP_CYC     = 20,
    parameter int STEPS_PER_DEG = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  S_out_teta,
    input  logic [1:0]  S_out_fi,
    input  logic        zero_teta,
    input  logic        zero_fi,
    output logic        step_teta,
    output logic        step_fi,
    output logic        dir_teta,
    output logic        dir_fi,
    output logic [15:0] teta_actual,
    output logic [15:0] fi_actual,
    output logic        busy_teta,
    output logic        busy_fi,
    output logic        cmd_err
);

    logic [ANGLE_W-1:0] w_teta_angle;
    logic [ANGLE_W-1:0] w_fi_angle;
    logic               w_teta_ill;
    logic               w_fi_ill;
    logic               cmd_err_q;

    stepper_axis_channel #(
        .STEP_PERIOD   (STEP_PERIOD),
        .PULSE_W       (PULSE_W),
        .SETUP_CYC     (SETUP_CYC),
        .STEPS_PER_DEG (STEPS_PER_DEG)
    ) u_teta (
        .clk     (clk),
        .rst_n   (rst_n),
        .cmd_i   (S_out_teta),
        .zero_i  (zero_teta),
        .step_o  (step_teta),
        .dir_o   (dir_teta),
        .angle_o (w_teta_angle),
        .busy_o  (busy_teta),
        .ill_o   (w_teta_ill)
    );

    stepper_axis_channel #(
        .STEP_PERIOD   (STEP_PERIOD),
        .PULSE_W       (PULSE_W),
        .SETUP_CYC     (SETUP_CYC),
        .STEPS_PER_DEG (STEPS_PER_DEG)
    ) u_fi (
        .clk     (clk),
        .rst_n   (rst_n),
        .cmd_i   (S_out_fi),
        .zero_i  (zero_fi),
        .step_o  (step_fi),
        .dir_o   (dir_fi),
        .angle_o (w_fi_angle),
        .busy_o  (busy_fi),
        .ill_o   (w_fi_ill)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_err_q <= 1'b0;
        end else if (w_teta_ill || w_fi_ill) begin
            cmd_err_q <= 1'b1;
        end
    end

    assign teta_actual = {{(16-ANGLE_W){1'b0}}, w_teta_angle};
    assign fi_actual   = {{(16-ANGLE_W){1'b0}}, w_fi_angle};
    assign cmd_err     = cmd_err_q;

endmodule

`default_nettype wire

// File: tb/tb_stepper_axis_driver.sv
// ============================================================================
// tb_stepper_axis_driver : directed bench for stepper_axis_driver with small
//                          timing parameters (8/2/2/4).
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_stepper_axis_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  S_out_teta;
    logic [1:0]  S_out_fi;
    logic        zero_teta;
    logic        zero_fi;
    logic        step_teta;
    logic        step_fi;
    logic        dir_teta;
    logic        dir_fi;
    logic [15:0] teta_actual;
    logic [15:0] fi_actual;
    logic        busy_teta;
    logic        busy_fi;
    logic        cmd_err;

    int checks   = 0;
    int failures = 0;
    int n;

    stepper_axis_driver #(
        .STEP_PERIOD   (8),
        .PULSE_W       (2),
        .SETUP_CYC     (2),
        .STEPS_PER_DEG (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .S_out_teta  (S_out_teta),
        .S_out_fi    (S_out_fi),
        .zero_teta   (zero_teta),
        .zero_fi     (zero_fi),
        .step_teta   (step_teta),
        .step_fi     (step_fi),
        .dir_teta    (dir_teta),
        .dir_fi      (dir_fi),
        .teta_actual (teta_actual),
        .fi_actual   (fi_actual),
        .busy_teta   (busy_teta),
        .busy_fi     (busy_fi),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance until the selected step pin rises; cyc = edges consumed.
    task automatic wait_rise(input bit fi_axis, output int cyc);
        logic prev;
        logic cur;
        bit   found;
        cyc   = 0;
        found = 1'b0;
        prev  = fi_axis ? step_fi : step_teta;
        while (!found && cyc < 100) begin
            tick(1);
            cyc++;
            cur = fi_axis ? step_fi : step_teta;
            if (!prev && cur) found = 1'b1;
            prev = cur;
        end
        checks++;
        assert (found) else begin
            failures++;
            $error("FAIL step_rise_timeout observed=%0d expected=1", found);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        S_out_teta = 2'b00;
        S_out_fi   = 2'b00;
        zero_teta  = 1'b0;
        zero_fi    = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        check("rst_step_teta", step_teta, 0);
        check("rst_busy_teta", busy_teta, 0);
        check("rst_dir_teta", dir_teta, 0);
        check("rst_teta_actual", teta_actual, 0);
        check("rst_fi_actual", fi_actual, 0);
        check("rst_busy_fi", busy_fi, 0);
        check("rst_cmd_err", cmd_err, 0);

        // Start from reset: positive teta
        S_out_teta = 2'b10;
        tick(1);
        check("start_dir_early", dir_teta, 0);
        check("start_busy_early", busy_teta, 0);
        tick(1);
        check("start_dir", dir_teta, 1);
        check("start_busy", busy_teta, 1);
        check("start_step_setup", step_teta, 0);
        tick(1);
        check("start_step_setup2", step_teta, 0);
        tick(1);
        check("first_step_rise", step_teta, 1);
        check("first_step_angle", teta_actual, 0);
        check("first_step_sub", dut.u_teta.sub_q, 1);
        tick(1);
        check("pulse_hi_2nd", step_teta, 1);
        tick(1);
        check("pulse_fall", step_teta, 0);
        tick(5);
        check("pulse_lo_end", step_teta, 0);
        tick(1);
        check("second_step_rise", step_teta, 1);
        wait_rise(1'b0, n);
        check("period_3rd", n, 8);
        check("angle_3rd", teta_actual, 0);
        wait_rise(1'b0, n);
        check("period_4th", n, 8);
        check("angle_4th", teta_actual, 1);

        // Negative wrap from 0 on fi
        do_reset();
        S_out_fi = 2'b01;
        wait_rise(1'b1, n);
        check("fi_first_latency", n, 4);
        check("fi_first_angle", fi_actual, 359);
        check("fi_first_sub", dut.u_fi.sub_q, 3);
        check("fi_dir", dir_fi, 0);
        check("teta_idle_indep", busy_teta, 0);
        for (int i = 1; i <= 4; i++) begin
            wait_rise(1'b1, n);
            if (i == 3) check("fi_angle_step4", fi_actual, 359);
        end
        check("fi_angle_step5", fi_actual, 358);
        S_out_fi = 2'b00;

        // Positive wrap at 359
        do_reset();
        S_out_teta = 2'b10;
        for (int i = 1; i <= 1440; i++) begin
            wait_rise(1'b0, n);
            if (i == 1439) check("wrap_pre_angle", teta_actual, 359);
        end
        check("wrap_angle", teta_actual, 0);
        check("wrap_sub", dut.u_teta.sub_q, 0);

        // Reversal mid-stream
        do_reset();
        S_out_teta = 2'b10;
        for (int i = 1; i <= 5; i++) wait_rise(1'b0, n);
        check("rev_pre_angle", teta_actual, 1);
        S_out_teta = 2'b01;
        tick(1);
        check("rev_hi_kept", step_teta, 1);
        check("rev_dir_kept", dir_teta, 1);
        tick(1);
        check("rev_fall", step_teta, 0);
        tick(5);
        check("rev_dir_lo_end", dir_teta, 1);
        tick(1);
        check("rev_dir_flip", dir_teta, 0);
        check("rev_setup_step", step_teta, 0);
        check("rev_setup_busy", busy_teta, 1);
        tick(1);
        check("rev_setup_step2", step_teta, 0);
        tick(1);
        check("rev_first_neg_step", step_teta, 1);
        check("rev_first_neg_angle", teta_actual, 1);
        for (int i = 2; i <= 5; i++) begin
            wait_rise(1'b0, n);
            if (i == 2) check("rev_second_angle", teta_actual, 0);
        end
        check("rev_return_angle", teta_actual, 0);
        check("rev_return_sub", dut.u_teta.sub_q, 0);

        // Illegal code on fi while teta steps negative
        S_out_fi = 2'b11;
        tick(2);
        check("ill_cmd_err", cmd_err, 1);
        check("ill_busy_fi", busy_fi, 0);
        check("ill_step_fi", step_fi, 0);
        wait_rise(1'b0, n);
        wait_rise(1'b0, n);
        check("ill_teta_period", n, 8);
        check("ill_teta_angle", teta_actual, 359);
        check("ill_teta_dir", dir_teta, 0);
        S_out_fi = 2'b00;
        tick(3);
        check("ill_cmd_err_sticky", cmd_err, 1);
        check("ill_fi_idle", busy_fi, 0);

        // Home strobe priority and reset mid-pulse
        do_reset();
        check("home_rst_cmd_err", cmd_err, 0);
        S_out_teta = 2'b10;
        for (int i = 1; i <= 68; i++) wait_rise(1'b0, n);
        check("home_pre_angle", teta_actual, 17);
        tick(7);
        zero_teta = 1'b1;
        tick(1);
        zero_teta = 1'b0;
        check("home_step_rise", step_teta, 1);
        check("home_angle", teta_actual, 0);
        check("home_sub", dut.u_teta.sub_q, 0);
        wait_rise(1'b0, n);
        check("home_next_period", n, 8);
        check("home_next_sub", dut.u_teta.sub_q, 1);
        check("home_next_angle", teta_actual, 0);
        rst_n = 1'b0;
        tick(1);
        check("rst_mid_step", step_teta, 0);
        check("rst_mid_busy", busy_teta, 0);
        check("rst_mid_dir", dir_teta, 0);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
